// File: rtl/triumph_mem_fabric.sv
// triumph_mem_fabric
// Shared single-port 32-bit SRAM for an instruction port and a data port,
// with a small MMIO block: a display register and a count of 1 s ticks.
//
// Ports
//   clk_i, rstn_i                  clock, asynchronous active-low reset
//   instr_req_i / instr_addr_i     fetch request and byte address
//   instr_gnt_o                    fetch accepted this cycle (combinational)
//   instr_rvalid_o / instr_rdata_o fetch response, one cycle after the grant
//   data_req_i / data_we_i / data_be_i / data_addr_i / data_wdata_i
//                                  load/store request
//   data_gnt_o                     load/store accepted this cycle (combinational)
//   data_rvalid_o / data_rdata_o / data_err_o
//                                  response one cycle after the grant
//   data_display_o                 display register contents
//   flag1s_o                       one-cycle pulse every TICK_CYCLES cycles
module triumph_mem_fabric #(
  parameter int          MEM_WORDS    = 4096,
  parameter int          TICK_CYCLES  = 50000000,
  parameter int          STARVE_LIMIT = 4,
  parameter logic [31:0] DISPLAY_ADDR = 32'h8000_0000,
  parameter logic [31:0] TIMER_ADDR   = 32'h8000_0004
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic [31:0] data_display_o,
  output logic        flag1s_o
);

  localparam int             AW         = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int             SW         = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [32:0]    MEM_BYTES  = 33'(MEM_WORDS) * 33'd4;
  localparam logic [SW-1:0]  STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [31:0]    TICK_LAST  = 32'(TICK_CYCLES - 1);

  // Byte-lane merge used by both the SRAM and the display register.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] merged;
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = be[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
    return merged;
  endfunction

  logic [31:0]   mem [MEM_WORDS];
  logic [SW-1:0] starve_cnt;
  logic          instr_gnt;
  logic          data_gnt;
  logic          instr_in_mem;
  logic          data_in_mem;
  logic          data_is_disp;
  logic          data_is_timer;
  logic          data_is_err;
  logic [AW-1:0] mem_idx;
  logic [31:0]   mem_word;
  logic [31:0]   data_load;
  logic [31:0]   cycle_cnt;
  logic [31:0]   tick_cnt;
  logic [31:0]   display;
  logic          instr_rvalid;
  logic [31:0]   instr_rdata;
  logic          data_rvalid;
  logic [31:0]   data_rdata;
  logic          data_err;
  logic          flag1s;

  // Address decode, fixed-priority arbitration with starvation escape, and
  // the single shared SRAM address. Grants are forced low while in reset so
  // nothing is accepted during the reset window.
  always_comb begin
    instr_in_mem  = ({1'b0, instr_addr_i} < MEM_BYTES);
    data_in_mem   = ({1'b0, data_addr_i} < MEM_BYTES);
    data_is_disp  = (data_addr_i[31:2] == DISPLAY_ADDR[31:2]);
    data_is_timer = (data_addr_i[31:2] == TIMER_ADDR[31:2]);
    data_is_err   = !(data_in_mem || data_is_disp || data_is_timer);
    instr_gnt     = 1'b0;
    data_gnt      = 1'b0;
    if (!rstn_i) begin
      instr_gnt = 1'b0;
      data_gnt  = 1'b0;
    end else if (instr_req_i && (!data_req_i || (starve_cnt == STARVE_MAX))) begin
      instr_gnt = 1'b1;
    end else if (data_req_i) begin
      data_gnt = 1'b1;
    end else begin
      instr_gnt = 1'b0;
      data_gnt  = 1'b0;
    end
    mem_idx  = instr_gnt ? instr_addr_i[AW+1:2] : data_addr_i[AW+1:2];
    mem_word = mem[mem_idx];
  end

  // Load data selection for the data port; stores and bad addresses return 0.
  always_comb begin
    data_load = 32'd0;
    if (data_we_i) begin
      data_load = 32'd0;
    end else if (data_in_mem) begin
      data_load = mem_word;
    end else if (data_is_disp) begin
      data_load = display;
    end else if (data_is_timer) begin
      data_load = tick_cnt;
    end else begin
      data_load = 32'd0;
    end
  end

  // SRAM write port; contents are deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (data_gnt && data_we_i && data_in_mem) begin
      mem[mem_idx] <= merge_bytes(mem_word, data_wdata_i, data_be_i);
    end
  end

  // Starvation counter: counts consecutive denied fetch cycles, saturating.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      starve_cnt <= '0;
    end else if (!instr_req_i || instr_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Response registers; rdata holds its last value between grants.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      instr_rvalid <= 1'b0;
      instr_rdata  <= 32'd0;
      data_rvalid  <= 1'b0;
      data_rdata   <= 32'd0;
      data_err     <= 1'b0;
    end else begin
      instr_rvalid <= instr_gnt;
      data_rvalid  <= data_gnt;
      data_err     <= data_gnt && data_is_err;
      if (instr_gnt) begin
        instr_rdata <= instr_in_mem ? mem_word : 32'd0;
      end
      if (data_gnt) begin
        data_rdata <= data_load;
      end
    end
  end

  // Display register with byte-enable writes.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      display <= 32'd0;
    end else if (data_gnt && data_we_i && data_is_disp) begin
      display <= merge_bytes(display, data_wdata_i, data_be_i);
    end
  end

  // Tick generator: pulse on the last cycle of each period; the pulse count
  // advances on the same edge so a load always matches the pulses seen.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cycle_cnt <= 32'd0;
      tick_cnt  <= 32'd0;
      flag1s    <= 1'b0;
    end else if (cycle_cnt == TICK_LAST) begin
      cycle_cnt <= 32'd0;
      tick_cnt  <= tick_cnt + 32'd1;
      flag1s    <= 1'b1;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      flag1s    <= 1'b0;
    end
  end

  assign instr_gnt_o    = instr_gnt;
  assign data_gnt_o     = data_gnt;
  assign instr_rvalid_o = instr_rvalid;
  assign instr_rdata_o  = instr_rdata;
  assign data_rvalid_o  = data_rvalid;
  assign data_rdata_o   = data_rdata;
  assign data_err_o     = data_err;
  assign data_display_o = display;
  assign flag1s_o       = flag1s;

endmodule

// File: doc/triumph_mem_fabric.md
TRIUMPH_MEM_FABRIC -- requirements
Module: triumph_mem_fabric

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- MEM_WORDS, 4096, depth of the shared 32-bit SRAM in words.
- TICK_CYCLES, 50000000, period of flag1s_o in clk_i cycles.
- STARVE_LIMIT, 4, maximum consecutive denied instruction requests.
- DISPLAY_ADDR, 32'h8000_0000, byte address of the display register.
- TIMER_ADDR, 32'h8000_0004, byte address of the free-running tick counter.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk_i, in, 1, single clock.
- rstn_i, in, 1, asynchronous active-low reset.
- instr_req_i, in, 1, instruction fetch request.
- instr_addr_i, in, 32, fetch byte address.
- instr_gnt_o, out, 1, fetch accepted this cycle.
- instr_rvalid_o, out, 1, fetch data valid.
- instr_rdata_o, out, 32, fetch data.
- data_req_i, in, 1, load/store request.
- data_we_i, in, 1, 1 = store.
- data_be_i, in, 4, store byte enables.
- data_addr_i, in, 32, load/store byte address.
- data_wdata_i, in, 32, store data.
- data_gnt_o, out, 1, load/store accepted this cycle.
- data_rvalid_o, out, 1, response valid (loads and stores).
- data_rdata_o, out, 32, load data.
- data_err_o, out, 1, access error, qualified by data_rvalid_o.
- data_display_o, out, 32, display register contents.
- flag1s_o, out, 1, one-cycle tick pulse.

Function
REQ-003 One shared single-port memory array of MEM_WORDS x 32 bits; word index is addr[31:2]; addr[1:0] is ignored.
REQ-004 At most one grant per cycle; gnt is combinational from req and arbiter state.
REQ-005 The data port wins when both ports request, unless the starvation counter equals STARVE_LIMIT, in which case the instruction port wins.
REQ-006 The starvation counter increments on each cycle the instruction port requests and is not granted, clears on an instruction grant or when instr_req_i is low, and saturates at STARVE_LIMIT.
REQ-007 Read latency: rvalid is asserted exactly one cycle after gnt, with rdata valid in that same cycle; there is no back-pressure on responses.
REQ-008 A granted store writes only the bytes with data_be_i set, at the clock edge of the grant; data_rvalid_o pulses the next cycle with data_rdata_o = 0.
REQ-009 A load in the cycle after a store to the same word returns the updated data.
REQ-010 Memory region: byte addresses 0 .. MEM_WORDS*4-1.
REQ-011 DISPLAY_ADDR: a store applies byte enables to data_display_o; a load returns data_display_o.
REQ-012 TIMER_ADDR: a load returns the 32-bit count of flag1s_o pulses since reset; a store is ignored with no error.
REQ-013 Data access to any other address: granted; a store is dropped; the response has data_rdata_o = 0 and data_err_o = 1.
REQ-014 Instruction fetch outside the memory region: granted; instr_rdata_o = 0 and no error output; MMIO is not reachable from the instruction port.
REQ-015 flag1s_o pulses high for one cycle when the internal cycle counter reaches TICK_CYCLES-1, then the counter wraps to 0.
REQ-016 The tick count register wraps from 32'hFFFF_FFFF to 0.
REQ-017 When the memory is not granted, rdata holds its last value; rvalid is 0.

Reset
REQ-018 While rstn_i = 0 (asynchronous), the following hold:
- all gnt, rvalid and err outputs = 0;
- instr_rdata_o = data_rdata_o = 0;
- data_display_o = 0;
- flag1s_o = 0;
- cycle, tick and starvation counters = 0.
REQ-019 Memory array contents are not reset.
REQ-020 A request granted in the cycle reset asserts produces no response after reset is released.
REQ-021 The first grant is possible in the first cycle after rstn_i rises.

Verification
REQ-022 Byte-enable store: store 32'hDEADBEEF to 0x10 with be=4'hF, then store 32'h0000_0011 with be=4'h1, then load 0x10 -> rdata = 32'hDEADBE11 one cycle after the load grant.
REQ-023 Contention: both ports request continuously with STARVE_LIMIT=4 -> grant pattern is D,D,D,D,I repeating; every instruction fetch is returned in order.
REQ-024 MMIO: store 32'h0000_1234 to DISPLAY_ADDR -> data_display_o = 32'h1234 the next cycle; a load from 0x9000_0000 -> data_err_o = 1, rdata = 0, and data_display_o is unchanged.
REQ-025 Tick: TICK_CYCLES = 10 -> flag1s_o pulses on cycles 10, 20, 30 after reset release; a TIMER_ADDR load after the third pulse returns 3.
REQ-026 Reset mid-operation: assert rstn_i in the cycle of a granted load -> rvalid stays 0 throughout, and all outputs are at their reset values within the same cycle.
REQ-027 Fetch beyond the memory region: fetch at MEM_WORDS*4 -> instr_rvalid_o = 1 and instr_rdata_o = 0.
